axi_store_slave: RTL and testbench



---
 rtl/axi_store_slave_if.sv | 33 +++
 rtl/axi_store_slave.sv | 121 ++++++++++++
 tb/tb_axi_store_slave.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_store_slave_if.sv
// axi_store_slave_if: AXI3 write-channel bundle between the store bus arbiter and the store slave.
interface axi_store_slave_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_store_slave.sv
// axi_store_slave: single-outstanding AXI3 write responder committing beats to a word-addressed RAM port.
module axi_store_slave #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  axi_store_slave_if.slave  bus,
  output logic [3:0]        mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state_q, state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0] bid_q, bid_d, mem_wen_q, mem_wen_d, id_q, id_d, len_q, len_d, cnt_q, cnt_d;
  logic [1:0] bresp_q, bresp_d, burst_q, burst_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d, addr_q, addr_d, mask, addr_nxt;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic err_q, err_d, awerr_q, awerr_d;
  logic aw_hs, w_hs, b_hs, last, beat_err, aw_bad;
  logic unused_ok;
  assign unused_ok = ^{bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0], bus.awlock, bus.awcache, bus.awprot};
  always_comb begin
    aw_hs = bus.awvalid & awready_q;
    w_hs = bus.wvalid & wready_q;
    b_hs = bus.bready & bvalid_q;
    last = cnt_q == len_q;
    beat_err = (bus.wid != id_q) | (bus.wlast != last);
    aw_bad = (bus.awsize != 3'b010) | (bus.awburst == 2'b11) |
             ((bus.awburst == 2'b10) & !(bus.awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));
    // WRAP lengths are 2^n-1, so awlen itself is the mask of the wrapping low bits
    mask = MEM_AW'(len_q);
    addr_nxt = burst_q == 2'b00 ? addr_q :
               burst_q == 2'b10 ? (addr_q & ~mask) | ((addr_q + 1'b1) & mask) : addr_q + 1'b1;
    state_d = state_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    burst_d = burst_q;
    cnt_d = cnt_q;
    err_d = err_q;
    awerr_d = awerr_q;
    bid_d = bid_q;
    bresp_d = bresp_q;
    mem_wen_d = '0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (aw_hs) begin
      state_d = DATA;
      id_d = bus.awid;
      addr_d = bus.awaddr[MEM_AW+1:2];
      len_d = bus.awlen;
      burst_d = bus.awburst;
      cnt_d = '0;
      err_d = aw_bad;
      awerr_d = aw_bad;
    end
    if (w_hs) begin
      mem_wen_d = awerr_q ? 4'h0 : bus.wstrb;
      mem_addr_d = addr_q;
      mem_wdata_d = bus.wdata;
      addr_d = addr_nxt;
      cnt_d = cnt_q + 4'd1;
      err_d = err_q | beat_err;
      if (last) begin
        state_d = RESP;
        bid_d = id_q;
        bresp_d = (err_q | beat_err) ? 2'b10 : 2'b00;
      end
    end
    if (b_hs) state_d = IDLE;
    awready_d = state_d == IDLE;
    wready_d = state_d == DATA;
    bvalid_d = state_d == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q <= '0;
      bresp_q <= '0;
      mem_wen_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      burst_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      awerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bid_q <= bid_d;
      bresp_q <= bresp_d;
      mem_wen_q <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      burst_q <= burst_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      awerr_q <= awerr_d;
    end
  end
  assign bus.awready = awready_q;
  assign bus.wready = wready_q;
  assign bus.bvalid = bvalid_q;
  assign bus.bid = bid_q;
  assign bus.bresp = bresp_q;
  assign mem_wen = mem_wen_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_axi_store_slave.sv
// tb_axi_store_slave: randomized and directed scoreboard bench for axi_store_slave.
module tb_axi_store_slave;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_store_slave_if bus();
  logic [3:0] mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  axi_store_slave #(.MEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );
  typedef struct {
    logic [3:0] wen;
    logic [AW-1:0] addr;
    logic [31:0] data;
    bit chk_wen;
    bit chk_addr;
  } mexp_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;
  mexp_t mq[$];
  bexp_t bq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit prev_beat = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/unexpected expected=event", name);
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_beat <= bus.wvalid & bus.wready & !rst;
    if (mon_en && bus.bvalid && bus.bready && bq.size() > 0) void'(bq.pop_front());
  end
  always @(negedge clk) begin : mon
    mexp_t e;
    if (mon_en) begin
      if (prev_beat) begin
        if (mq.size() == 0) fail("mem_unexpected_beat");
        else begin
          e = mq.pop_front();
          chk("mem_wdata", mem_wdata, e.data);
          if (e.chk_addr) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.chk_wen) chk("mem_wen", 32'(mem_wen), 32'(e.wen));
        end
      end else chk("mem_wen_idle", 32'(mem_wen), 32'd0);
      if (bus.bvalid) begin
        if (bq.size() == 0) fail("b_unexpected");
        else begin
          chk("bid", 32'(bus.bid), 32'(bq[0].id));
          chk("bresp", 32'(bus.bresp), 32'(bq[0].resp));
        end
      end
    end
  end
  task automatic txn(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input int bad_wid,
                     input int bad_last, input logic [15:0] gaps, input int bdelay,
                     input bit fast_chk, input int rst_beat);
    int n, start, first_err, t, aw_cyc, b_cyc, a;
    bit wrap_ok, aw_err, data_err;
    logic [31:0] d;
    logic [3:0] s;
    mexp_t e;
    bexp_t b;
    n = int'(len) + 1;
    start = int'(addr[AW+1:2]);
    wrap_ok = n == 2 || n == 4 || n == 8 || n == 16;
    aw_err = size != 3'd2 || burst == 2'd3 || (burst == 2'd2 && !wrap_ok);
    first_err = n;
    if (bad_wid >= 0 && bad_wid < first_err) first_err = bad_wid;
    if (bad_last >= 0 && bad_last < first_err) first_err = bad_last;
    data_err = first_err < n;
    b.id = id;
    b.resp = (aw_err || data_err) ? 2'b10 : 2'b00;
    bq.push_back(b);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awlock = 2'($urandom); bus.awcache = 4'($urandom); bus.awprot = 3'($urandom);
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1; bus.wid = id; bus.wdata = 32'hBAD0_0000; bus.wstrb = 4'hF; bus.wlast = len == 0;
    bus.bready = bdelay == 0;
    t = 0;
    while (!bus.awready && t < 100) begin @(negedge clk); t++; end
    if (!bus.awready) fail("aw_timeout");
    aw_cyc = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0;
    chk("awready_after_aw", 32'(bus.awready), 32'd0);
    chk("wready_after_aw", 32'(bus.wready), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (gaps[k]) begin bus.wvalid = 1'b0; @(negedge clk); end
      d = $urandom;
      s = 4'($urandom);
      bus.wvalid = 1'b1;
      bus.wid = (k == bad_wid) ? id ^ 4'h7 : id;
      bus.wlast = (k == n - 1) ^ (k == bad_last);
      bus.wdata = d;
      bus.wstrb = s;
      t = 0;
      while (!bus.wready && t < 100) begin @(negedge clk); t++; end
      if (!bus.wready) fail("w_timeout");
      if (k == rst_beat) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        rst = 1'b0;
        bus.wvalid = 1'b0;
        bq.delete();
        mq.delete();
        return;
      end
      a = burst == 2'd0 ? start : burst == 2'd2 ? start - start % n + (start % n + k) % n
                                                : (start + k) % (1 << AW);
      e.data = d;
      e.wen = aw_err ? 4'h0 : s;
      e.addr = AW'(a);
      e.chk_wen = aw_err || k < first_err || (k == first_err && k == bad_wid && k != bad_last);
      e.chk_addr = !(burst == 2'd3 || (burst == 2'd2 && !wrap_ok));
      mq.push_back(e);
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    t = 0;
    while (!bus.bvalid && t < 100) begin @(negedge clk); t++; end
    if (!bus.bvalid) fail("b_timeout");
    for (int i = 0; i < bdelay; i++) begin
      chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("awready_in_resp", 32'(bus.awready), 32'd0);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    b_cyc = cyc;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("bvalid_after_b", 32'(bus.bvalid), 32'd0);
    chk("awready_after_b", 32'(bus.awready), 32'd1);
    if (fast_chk) chk("latency", 32'(b_cyc - aw_cyc), 32'(n + 1));
  endtask
  initial begin
    int r, len, bw, bl;
    logic [1:0] burst;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'd1;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_awready", 32'(bus.awready), 32'd0);
    chk("reset_wready", 32'(bus.wready), 32'd0);
    chk("reset_bvalid", 32'(bus.bvalid), 32'd0);
    chk("reset_bid", 32'(bus.bid), 32'd0);
    chk("reset_bresp", 32'(bus.bresp), 32'd0);
    chk("reset_mem_wen", 32'(mem_wen), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("awready_after_reset", 32'(bus.awready), 32'd1);
    txn(4'd3, 32'h10, 4'd0, 3'd2, 2'd1, -1, -1, 16'h0, 0, 1'b1, -1);
    txn(4'd1, 32'hFF8, 4'd3, 3'd2, 2'd1, -1, -1, 16'h0004, 0, 1'b0, -1);
    txn(4'd4, 32'h18, 4'd3, 3'd2, 2'd2, -1, -1, 16'h0, 0, 1'b1, -1);
    txn(4'd6, 32'h20, 4'd2, 3'd2, 2'd2, -1, -1, 16'h0, 0, 1'b0, -1);
    txn(4'd7, 32'h40, 4'd3, 3'd2, 2'd1, -1, 1, 16'h0, 0, 1'b0, -1);
    txn(4'd2, 32'h80, 4'd0, 3'd2, 2'd1, 0, -1, 16'h0, 0, 1'b0, -1);
    txn(4'd9, 32'h100, 4'd1, 3'd2, 2'd1, -1, -1, 16'h0, 5, 1'b0, -1);
    txn(4'd12, 32'h44, 4'd1, 3'd3, 2'd1, -1, -1, 16'h0, 0, 1'b0, -1);
    txn(4'd13, 32'h50, 4'd2, 3'd2, 2'd0, -1, -1, 16'h0, 0, 1'b1, -1);
    txn(4'd10, 32'h200, 4'd7, 3'd2, 2'd1, -1, -1, 16'h0, 0, 1'b0, 2);
    txn(4'd11, 32'h300, 4'd0, 3'd2, 2'd1, -1, -1, 16'h0, 0, 1'b1, -1);
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      burst = r < 4 ? 2'd1 : r < 6 ? 2'd0 : r < 9 ? 2'd2 : 2'd3;
      len = burst == 2'd2 && $urandom_range(0, 3) != 0 ? (2 << $urandom_range(0, 3)) - 1
                                                       : int'($urandom_range(0, 15));
      bw = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, len)) : -1;
      bl = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, len)) : -1;
      txn(4'($urandom), $urandom, 4'(len), $urandom_range(0, 9) == 0 ? 3'd1 : 3'd2, burst,
          bw, bl, 16'($urandom & $urandom & $urandom), int'($urandom_range(0, 3)), 1'b0, -1);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
